// File: rtl/cpc_ram_xctl_pkg.sv
// Shared constants, FSM state type and page decode for the CPC RAM expansion controller.
package cpc_ram_xctl_pkg;

    localparam logic [2:0] MODE_NONE = 3'd0;
    localparam logic [2:0] MODE_P3_1 = 3'd1;
    localparam logic [2:0] MODE_ALL  = 3'd2;
    localparam logic [2:0] MODE_P3_3 = 3'd3;
    localparam logic [2:0] MODE_P1_4 = 3'd4;
    localparam logic [2:0] MODE_P1_5 = 3'd5;
    localparam logic [2:0] MODE_P1_6 = 3'd6;
    localparam logic [2:0] MODE_P1_7 = 3'd7;

    localparam logic [1:0] PAGE_1 = 2'd1;
    localparam logic [1:0] PAGE_3 = 2'd3;

    // Banking register is hit when D7:D6 carry this tag and A15 is low
    localparam logic [1:0] CFG_DATA_TAG = 2'b11;
    localparam logic       CFG_ADDR_A15 = 1'b0;

    typedef enum logic [1:0] {
        IDLE,
        QUAL,
        HOLD
    } xctl_state_t;

    typedef struct packed {
        logic       ext;
        logic [1:0] sub;
    } decode_t;

    function automatic decode_t decode_page(input logic [2:0] mode, input logic [1:0] page);
        decode_t r;
        r = '{ext: 1'b0, sub: 2'd0};
        case (mode)
            MODE_NONE: r = '{ext: 1'b0, sub: 2'd0};
            MODE_P3_1, MODE_P3_3: begin
                if (page == PAGE_3) r = '{ext: 1'b1, sub: 2'd3};
            end
            MODE_ALL: r = '{ext: 1'b1, sub: page};
            MODE_P1_4, MODE_P1_5, MODE_P1_6, MODE_P1_7: begin
                if (page == PAGE_1) r = '{ext: 1'b1, sub: mode[1:0]};
            end
            default: r = '{ext: 1'b0, sub: 2'd0};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/cpc_bus_sync.sv
// Multi-stage flop synchroniser for one asynchronous Z80 bus strobe.
module cpc_bus_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic async_in,
    output logic sync_out
);

    logic [STAGES-1:0] chain;

    // Deliberately unreset so a strobe held across reset is still seen afterwards
    always_ff @(posedge clk) begin
        chain <= {chain[STAGES-2:0], async_in};
    end

    assign sync_out = chain[STAGES-1];

endmodule

// File: rtl/cpc_ram_xctl.sv
// Clocked CPC 6128-style RAM expansion controller for 1..8 512K SRAMs.
// Define CPC_RAM_XCTL_READBACK_EN to enable config readback on IO port RB_PORT.
module cpc_ram_xctl
    import cpc_ram_xctl_pkg::*;
#(
    parameter int         NUM_SRAM      = 2,
    parameter int         SYNC_STAGES   = 2,
    parameter int         FILTER_CYCLES = 2,
    parameter logic [7:0] RB_PORT       = 8'hFE
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                IOREQ_B,
    input  logic                WR_B,
    input  logic                RD_B,
    input  logic                M1_B,
    input  logic                MREQ_B,
    input  logic [15:0]         A,
    input  logic [7:0]          D,
    output logic [7:0]          DOUT,
    output logic                DOE,
    output logic                RAMDIS,
    output logic [4:0]          RAMADRHI,
    output logic [NUM_SRAM-1:0] RAMCS_B
);

    localparam int         CS_W         = (NUM_SRAM > 1) ? $clog2(NUM_SRAM) : 0;
    localparam int         CHIP_W       = (CS_W > 0) ? CS_W : 1;
    localparam logic [3:0] FILTER_LIMIT = 4'(FILTER_CYCLES);

    logic              ioreq_s;
    logic              wr_s;
    logic              m1_s;
    logic              iowr;
    logic              cfg_match;
    logic [CHIP_W-1:0] chip_next;

    xctl_state_t       state;
    logic [3:0]        count;
    logic [2:0]        cfg_mode;
    logic [2:0]        cfg_bank;
    logic [CHIP_W-1:0] cfg_chip;
    decode_t           dec;
    logic              unused_bus;

    cpc_bus_sync #(.STAGES(SYNC_STAGES)) u_sync_ioreq (.clk(CLK), .async_in(IOREQ_B), .sync_out(ioreq_s));
    cpc_bus_sync #(.STAGES(SYNC_STAGES)) u_sync_wr    (.clk(CLK), .async_in(WR_B),    .sync_out(wr_s));
    cpc_bus_sync #(.STAGES(SYNC_STAGES)) u_sync_m1    (.clk(CLK), .async_in(M1_B),    .sync_out(m1_s));

    // M1 low with IORQ is an interrupt acknowledge, never a write
    assign iowr      = ~ioreq_s & ~wr_s & m1_s;
    assign cfg_match = (A[15] == CFG_ADDR_A15) & (D[7:6] == CFG_DATA_TAG);

    // Extra chip-select bits come inverted from A8 upward
    generate
        if (CS_W > 0) begin : g_chip_addr
            assign chip_next = ~A[8 +: CS_W];
        end else begin : g_chip_none
            assign chip_next = '0;
        end
    endgenerate

    // Reset lands in HOLD if the strobe is still low so that write cannot commit
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= iowr ? HOLD : IDLE;
            count    <= '0;
            cfg_mode <= '0;
            cfg_bank <= '0;
            cfg_chip <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (iowr) begin
                        count <= 4'd1;
                        state <= QUAL;
                    end
                end
                QUAL: begin
                    if (!iowr) begin
                        count <= '0;
                        state <= IDLE;
                    end else if (count < FILTER_LIMIT) begin
                        count <= count + 4'd1;
                    end else begin
                        if (cfg_match) begin
                            cfg_mode <= D[2:0];
                            cfg_bank <= D[5:3];
                            cfg_chip <= chip_next;
                        end
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (!iowr) begin
                        count <= '0;
                        state <= IDLE;
                    end
                end
                default: begin
                    count <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign dec      = decode_page(cfg_mode, A[15:14]);
    assign RAMDIS   = dec.ext;
    assign RAMADRHI = {cfg_bank, dec.sub};

    generate
        for (genvar i = 0; i < NUM_SRAM; i++) begin : g_cs
            assign RAMCS_B[i] = ~(dec.ext & ~MREQ_B & (cfg_chip == CHIP_W'(i)));
        end
    endgenerate

`ifdef CPC_RAM_XCTL_READBACK_EN
    logic rd_s;
    logic iord;

    cpc_bus_sync #(.STAGES(SYNC_STAGES)) u_sync_rd (.clk(CLK), .async_in(RD_B), .sync_out(rd_s));

    assign iord = ~ioreq_s & ~rd_s & m1_s & (A[15:8] == RB_PORT);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            DOE  <= 1'b0;
            DOUT <= 8'h00;
        end else begin
            DOE  <= iord;
            DOUT <= iord ? {CFG_DATA_TAG, cfg_bank, cfg_mode} : 8'h00;
        end
    end
`else
    assign DOE  = 1'b0;
    assign DOUT = 8'h00;
`endif

    assign unused_bus = ^{A, RD_B, (A[15:8] == RB_PORT)};

endmodule

// File: tb/tb_cpc_ram_xctl.sv
// Scoreboard bench for cpc_ram_xctl: random IO writes/reads against a config-level reference model.
module tb_cpc_ram_xctl;

    localparam int         NUM_SRAM      = 2;
    localparam int         SYNC_STAGES   = 2;
    localparam int         FILTER_CYCLES = 2;
    localparam logic [7:0] RB_PORT       = 8'hFE;
    localparam int         COMMIT_MIN    = FILTER_CYCLES + 1;

    logic                CLK = 1'b0;
    logic                RESET;
    logic                IOREQ_B, WR_B, RD_B, M1_B, MREQ_B;
    logic [15:0]         A;
    logic [7:0]          D;
    logic [7:0]          DOUT;
    logic                DOE;
    logic                RAMDIS;
    logic [4:0]          RAMADRHI;
    logic [NUM_SRAM-1:0] RAMCS_B;

    typedef struct {
        string               name;
        logic                ramdis;
        logic [4:0]          adrhi;
        logic [NUM_SRAM-1:0] cs_b;
        logic                doe;
        logic [7:0]          dout;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    logic probe_valid = 1'b0;
    int   checks = 0;
    int   errors = 0;

    int m_mode = 0;
    int m_bank = 0;
    int m_chip = 0;

    cpc_ram_xctl #(
        .NUM_SRAM(NUM_SRAM), .SYNC_STAGES(SYNC_STAGES),
        .FILTER_CYCLES(FILTER_CYCLES), .RB_PORT(RB_PORT)
    ) dut (
        .CLK(CLK), .RESET(RESET), .IOREQ_B(IOREQ_B), .WR_B(WR_B), .RD_B(RD_B),
        .M1_B(M1_B), .MREQ_B(MREQ_B), .A(A), .D(D), .DOUT(DOUT), .DOE(DOE),
        .RAMDIS(RAMDIS), .RAMADRHI(RAMADRHI), .RAMCS_B(RAMCS_B)
    );

    always #5 CLK = ~CLK;

    function automatic exp_t model_expect(input string name, input logic [15:0] addr,
                                          input logic mreq_b, input logic reading);
        exp_t e;
        int   page;
        int   sub;
        logic ext;
        logic rb;
        page = int'(addr) / 16384;
        ext  = 1'b0;
        sub  = 0;
        if ((m_mode == 1 || m_mode == 3) && page == 3) begin
            ext = 1'b1;
            sub = 3;
        end else if (m_mode == 2) begin
            ext = 1'b1;
            sub = page;
        end else if (m_mode >= 4 && page == 1) begin
            ext = 1'b1;
            sub = m_mode % 4;
        end
`ifdef CPC_RAM_XCTL_READBACK_EN
        rb = reading && ((int'(addr) / 256) == int'(RB_PORT));
`else
        rb = 1'b0;
`endif
        e.name   = name;
        e.ramdis = ext;
        e.adrhi  = 5'(m_bank * 4 + sub);
        for (int i = 0; i < NUM_SRAM; i++)
            e.cs_b[i] = !(ext && !mreq_b && (m_chip == i));
        e.doe    = rb;
        e.dout   = rb ? 8'(192 + m_bank * 8 + m_mode) : 8'h00;
        return e;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic checkOutput(input string name, input logic [15:0] addr,
                               input logic mreq_b, input logic reading);
        A      = addr;
        MREQ_B = mreq_b;
        exp_q.push_back(model_expect(name, addr, mreq_b, reading));
        probe_valid = 1'b1;
        tick(1);
        probe_valid = 1'b0;
    endtask

    // IO write held for 'cycles' clocks; data2 replaces data after change_at clocks (0 = never)
    task automatic applyStimulus(input logic [15:0] addr, input logic [7:0] data, input int cycles,
                                 input logic m1, input logic [7:0] data2, input int change_at);
        logic [7:0] seen;
        A = addr; D = data; M1_B = m1; MREQ_B = 1'b1; RD_B = 1'b1;
        if (cycles > 0) begin
            IOREQ_B = 1'b0;
            WR_B    = 1'b0;
        end
        for (int c = 1; c <= cycles; c++) begin
            tick(1);
            if (c == change_at) D = data2;
        end
        IOREQ_B = 1'b1; WR_B = 1'b1; M1_B = 1'b1;
        tick(SYNC_STAGES + 3);
        seen = (change_at == 0 || change_at >= SYNC_STAGES + COMMIT_MIN) ? data : data2;
        if (m1 && cycles >= COMMIT_MIN && !addr[15] && seen[7] && seen[6]) begin
            m_mode = int'(seen) % 8;
            m_bank = (int'(seen) / 8) % 8;
            m_chip = (~(int'(addr) / 256)) & (NUM_SRAM - 1);
        end
    endtask

    task automatic ioRead(input string name, input logic [15:0] addr);
        A = addr; MREQ_B = 1'b1; M1_B = 1'b1;
        IOREQ_B = 1'b0; RD_B = 1'b0;
        tick(SYNC_STAGES + 1);
        checkOutput(name, addr, 1'b1, 1'b1);
        IOREQ_B = 1'b1; RD_B = 1'b1;
        tick(SYNC_STAGES + 2);
        checkOutput({name, "_rel"}, addr, 1'b1, 1'b0);
    endtask

    always @(negedge CLK) begin
        if (probe_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL scoreboard_empty: actual probe with no entry, required queued entry");
            end else begin
                mon_e = exp_q.pop_front();
                if ({RAMDIS, RAMADRHI, RAMCS_B, DOE, DOUT} !==
                    {mon_e.ramdis, mon_e.adrhi, mon_e.cs_b, mon_e.doe, mon_e.dout}) begin
                    errors++;
                    $display("[TB] FAIL %s A=%h: actual ramdis=%b adrhi=%b cs_b=%b doe=%b dout=%h, required ramdis=%b adrhi=%b cs_b=%b doe=%b dout=%h",
                             mon_e.name, A, RAMDIS, RAMADRHI, RAMCS_B, DOE, DOUT,
                             mon_e.ramdis, mon_e.adrhi, mon_e.cs_b, mon_e.doe, mon_e.dout);
                end
            end
        end
    end

    initial begin
        #2000000;
        errors++;
        $display("[TB] FAIL watchdog: actual timeout, required completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        IOREQ_B = 1'b1; WR_B = 1'b1; RD_B = 1'b1; M1_B = 1'b1; MREQ_B = 1'b1;
        A = 16'h0000; D = 8'h00;
        RESET = 1'b1;
        tick(SYNC_STAGES + 3);
        checkOutput("reset_p3", 16'hC000, 1'b0, 1'b0);
        checkOutput("reset_p1", 16'h4000, 1'b0, 1'b0);
        RESET = 1'b0;
        tick(2);

        applyStimulus(16'h7E00, 8'hC1, 6, 1'b1, 8'h00, 0);
        checkOutput("m1_p3", 16'hC000, 1'b0, 1'b0);
        checkOutput("m1_p1", 16'h4000, 1'b0, 1'b0);
        checkOutput("m1_nomreq", 16'hC000, 1'b1, 1'b0);

        applyStimulus(16'h7F00, 8'hCC, 6, 1'b1, 8'h00, 0);
        checkOutput("m4_p1", 16'h4000, 1'b0, 1'b0);
        checkOutput("m4_p3", 16'hC000, 1'b0, 1'b0);

        applyStimulus(16'h7FC2, 8'h82, 6, 1'b1, 8'h00, 0);
        checkOutput("no_tag", 16'h4000, 1'b0, 1'b0);
        applyStimulus(16'hFF00, 8'hC2, 6, 1'b1, 8'h00, 0);
        checkOutput("a15_high", 16'h4000, 1'b0, 1'b0);
        applyStimulus(16'h7F00, 8'hC2, FILTER_CYCLES - 1, 1'b1, 8'h00, 0);
        checkOutput("glitch", 16'h4000, 1'b0, 1'b0);
        applyStimulus(16'h7E00, 8'hC2, 8, 1'b0, 8'h00, 0);
        checkOutput("inta", 16'h4000, 1'b0, 1'b0);

        applyStimulus(16'h7E00, 8'hC1, 40, 1'b1, 8'hC2, 20);
        checkOutput("long_p3", 16'hC000, 1'b0, 1'b0);
        checkOutput("long_p0", 16'h0000, 1'b0, 1'b0);

        applyStimulus(16'h7F00, 8'hC2, 6, 1'b1, 8'h00, 0);
        checkOutput("m2_p0", 16'h0000, 1'b0, 1'b0);
        checkOutput("m2_p2", 16'h8000, 1'b0, 1'b0);

        // Reset while qualifying, strobe kept low across and after it
        A = 16'h7E00; D = 8'hC5; M1_B = 1'b1; MREQ_B = 1'b1;
        IOREQ_B = 1'b0; WR_B = 1'b0;
        tick(SYNC_STAGES + 1);
        RESET = 1'b1;
        tick(1);
        RESET = 1'b0;
        m_mode = 0; m_bank = 0; m_chip = 0;
        tick(10);
        IOREQ_B = 1'b1; WR_B = 1'b1;
        tick(SYNC_STAGES + 3);
        checkOutput("rst_qual_p1", 16'h4000, 1'b0, 1'b0);
        checkOutput("rst_qual_p0", 16'h0000, 1'b0, 1'b0);
        applyStimulus(16'h7E00, 8'hC5, 6, 1'b1, 8'h00, 0);
        checkOutput("after_rst_p1", 16'h4000, 1'b0, 1'b0);

        applyStimulus(16'h7F00, 8'hDE, 6, 1'b1, 8'h00, 0);
        ioRead("rb_port", 16'hFE00);
        ioRead("rb_other", 16'hFD00);

        for (int it = 0; it < 40; it++) begin
            logic [15:0] addr;
            logic [7:0]  data;
            logic [15:0] raddr;
            int          len;
            addr = 16'($urandom);
            if ($urandom_range(0, 3) != 0) addr[15] = 1'b0;
            data = 8'($urandom);
            if ($urandom_range(0, 3) != 0) data[7:6] = 2'b11;
            if (FILTER_CYCLES > 1 && $urandom_range(0, 4) == 0)
                len = $urandom_range(1, FILTER_CYCLES - 1);
            else
                len = $urandom_range(COMMIT_MIN + 1, COMMIT_MIN + 8);
            applyStimulus(addr, data, len, 1'b1, 8'h00, 0);
            for (int p = 0; p < 2; p++)
                checkOutput("rand", 16'($urandom), 1'($urandom_range(0, 1)), 1'b0);
            if (it % 5 == 0) begin
                raddr = 16'($urandom);
                if ($urandom_range(0, 1) == 1) raddr[15:8] = RB_PORT;
                ioRead("rand_rd", raddr);
            end
        end

        tick(2);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: actual %0d left, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
